// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle RV32I control sequencer.
package mc_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_IMM   = 2'b01;
  localparam logic [1:0] PC_ALU   = 2'b10;

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Unified memory port: request/ready handshake plus returned read data.
interface mc_ctrl_fsm_if;
  logic [31:0] instr_in;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic        mem_addr_sel;

  modport master (output mem_req, mem_we, mem_addr_sel, input mem_ready, instr_in);
  modport slave  (input mem_req, mem_we, mem_addr_sel, output mem_ready, instr_in);
endinterface

// File: rtl/mc_alu_decode.sv
// Combinational opcode/funct decode to ALU control and legality.
module mc_alu_decode
  import mc_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [3:0] alu_op,
  output logic       alu_src,
  output logic       illegal
);

  always_comb begin
    alu_op  = ALU_ADD;
    alu_src = 1'b0;
    illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case ({funct7, funct3})
          {F7_BASE, 3'b000}: alu_op = ALU_ADD;
          {F7_ALT,  3'b000}: alu_op = ALU_SUB;
          {F7_BASE, 3'b001}: alu_op = ALU_SLL;
          {F7_BASE, 3'b010}: alu_op = ALU_SLT;
          {F7_BASE, 3'b011}: alu_op = ALU_SLTU;
          {F7_BASE, 3'b100}: alu_op = ALU_XOR;
          {F7_BASE, 3'b101}: alu_op = ALU_SRL;
          {F7_ALT,  3'b101}: alu_op = ALU_SRA;
          {F7_BASE, 3'b110}: alu_op = ALU_OR;
          {F7_BASE, 3'b111}: alu_op = ALU_AND;
          default:           illegal = 1'b1;
        endcase
      end
      OP_IMM: begin
        alu_src = 1'b1;
        case (funct3)
          3'b000:  alu_op = ALU_ADD;
          3'b001:  alu_op = ALU_SLL;
          3'b010:  alu_op = ALU_SLT;
          3'b011:  alu_op = ALU_SLTU;
          3'b100:  alu_op = ALU_XOR;
          3'b101:  alu_op = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
          3'b110:  alu_op = ALU_OR;
          default: alu_op = ALU_AND;
        endcase
      end
      OP_LOAD, OP_STORE, OP_LUI, OP_AUIPC, OP_JALR: alu_src = 1'b1;
      OP_BRANCH: alu_op = ALU_SUB;
      OP_JAL:    alu_op = ALU_ADD;
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle RV32I control sequencer: one memory port, one ALU, many cycles.
module mc_ctrl_fsm
  import mc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  mc_ctrl_fsm_if.master    mem,
  input  logic             branch_taken,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic [3:0]       alu_op,
  output logic             alu_src,
  output logic [2:0]       state_o,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] retire_count
);

  localparam int             TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t        state;
  logic [6:0]    opcode, funct7;
  logic [2:0]    funct3;
  logic [TW-1:0] tmo_cnt;
  logic [3:0]    dec_op;
  logic          dec_src, dec_illegal;
  logic          is_load, is_store, is_branch, waiting, tmo_hit, retire;
  logic          instr_unused;

  assign instr_unused = ^{mem.instr_in[24:15], mem.instr_in[11:7]};

  mc_alu_decode u_dec (
    .opcode (opcode),
    .funct3 (funct3),
    .funct7 (funct7),
    .alu_op (dec_op),
    .alu_src(dec_src),
    .illegal(dec_illegal)
  );

  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign state_o   = state;

  // Last permitted wait cycle without ready traps; ready in that cycle still completes.
  assign waiting = ((state == S_FETCH) || (state == S_MEM)) && !mem.mem_ready;
  assign tmo_hit = waiting && (tmo_cnt == TMO_LAST);
  assign retire  = ((state == S_EXEC) && is_branch) ||
                   ((state == S_MEM) && mem.mem_ready && is_store) ||
                   (state == S_WB);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      illegal      <= 1'b0;
      bus_err      <= 1'b0;
      retire_count <= '0;
      tmo_cnt      <= '0;
      opcode       <= '0;
      funct3       <= '0;
      funct7       <= '0;
    end else begin
      tmo_cnt <= (waiting && !tmo_hit) ? tmo_cnt + 1'b1 : '0;
      if (retire) retire_count <= retire_count + 1'b1;
      if (ir_write) begin
        opcode <= mem.instr_in[6:0];
        funct3 <= mem.instr_in[14:12];
        funct7 <= mem.instr_in[31:25];
      end
      if (tmo_hit) begin
        state   <= S_TRAP;
        bus_err <= 1'b1;
      end else begin
        case (state)
          S_IDLE:   state <= S_FETCH;
          S_FETCH:  if (mem.mem_ready) state <= S_DECODE;
          S_DECODE: if (dec_illegal) begin
                      state   <= S_TRAP;
                      illegal <= 1'b1;
                    end else state <= S_EXEC;
          S_EXEC:   state <= is_branch ? S_FETCH : (is_load || is_store) ? S_MEM : S_WB;
          S_MEM:    if (mem.mem_ready) state <= is_store ? S_FETCH : S_WB;
          S_WB:     state <= S_FETCH;
          default:  state <= S_TRAP;
        endcase
      end
    end
  end

  always_comb begin
    mem.mem_req      = 1'b0;
    mem.mem_we       = 1'b0;
    mem.mem_addr_sel = 1'b0;
    ir_write         = 1'b0;
    pc_write         = 1'b0;
    pc_src           = PC_PLUS4;
    reg_write        = 1'b0;
    mem_to_reg       = 1'b0;
    alu_op           = ALU_ADD;
    alu_src          = 1'b0;
    case (state)
      S_FETCH: begin
        mem.mem_req = 1'b1;
        ir_write    = mem.mem_ready;
      end
      S_EXEC: begin
        alu_op  = dec_op;
        alu_src = dec_src;
        if (is_branch) begin
          pc_write = 1'b1;
          pc_src   = branch_taken ? PC_IMM : PC_PLUS4;
        end
      end
      S_MEM: begin
        mem.mem_req      = 1'b1;
        mem.mem_addr_sel = 1'b1;
        mem.mem_we       = is_store;
        pc_write         = is_store && mem.mem_ready;
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = is_load;
        pc_write   = 1'b1;
        pc_src     = (opcode == OP_JAL) ? PC_IMM : (opcode == OP_JALR) ? PC_ALU : PC_PLUS4;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multi-cycle control sequencer for the RV32I datapath.
- Fetch, execute, memory access and writeback share one memory port and one ALU across several cycles instead of one.
- Sits between the unified memory interface (req/ready handshake) and the datapath.
- Owns the IR-latch, PC-update and register-file write strobes, plus a retired-instruction counter.

Parameters:
- TIMEOUT_CYCLES, 16: max cycles mem_req may stay high without mem_ready before bus-error trap.
- CNT_W, 32: width of retire_count.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- instr_in  input  32  memory read data; sampled as instruction on fetch completion
- mem_ready  input  1  memory access complete this cycle
- branch_taken  input  1  branch condition result from datapath comparator, valid in EXEC
- mem_req  output  1  memory access request
- mem_we  output  1  store strobe, valid with mem_req
- mem_addr_sel  output  1  0 = PC, 1 = ALU result
- ir_write  output  1  latch instr_in into IR
- pc_write  output  1  update PC this cycle
- pc_src  output  2  00 = PC+4, 01 = PC+imm, 10 = ALU result (JALR)
- reg_write  output  1  register-file write enable
- mem_to_reg  output  1  writeback source: 1 = memory data
- alu_op  output  4  0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLT, 1001 SLTU
- alu_src  output  1  ALU operand B: 1 = immediate
- state_o  output  3  current state, for debug
- illegal  output  1  sticky: illegal opcode or funct trap
- bus_err  output  1  sticky: memory timeout trap
- retire_count  output  CNT_W  instructions retired; wraps modulo 2^CNT_W

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- Outputs are decoded from the registered state and registered instruction fields (opcode, funct3, funct7 captured when ir_write is high).
- Reset (async, any time, including mid-access):
  - state = IDLE; illegal = 0; bus_err = 0; retire_count = 0; timeout counter = 0.
  - All strobes 0 while in IDLE; any access in flight is abandoned.
- IDLE -> FETCH unconditionally on the first clock after rst deasserts.
- FETCH:
  - mem_req = 1, mem_addr_sel = 0, mem_we = 0.
  - While mem_ready = 0: hold state.
  - On mem_ready = 1: ir_write = 1 in the same cycle, then -> DECODE.
- DECODE, one cycle:
  - Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111.
  - Opcode 0110011 with a funct3/funct7 pair outside the ALU table is illegal.
  - Illegal -> TRAP with illegal = 1; otherwise -> EXEC.
- EXEC, one cycle. alu_op and alu_src per instruction class:
  - R-type: table lookup, alu_src = 0.
  - I-type ALU: funct3 lookup; for funct3 101, funct7 = 0x20 selects SRA.
  - Load, store, LUI, AUIPC, JALR: ADD with alu_src = 1. JAL: ADD.
  - Branch: SUB with alu_src = 0. pc_write = 1, pc_src = 01 if branch_taken, else 00. retire_count += 1. Next state FETCH.
  - Load/store -> MEM. All others -> WB.
- MEM:
  - mem_req = 1, mem_addr_sel = 1, mem_we = 1 for store only.
  - Hold state until mem_ready.
  - Load -> WB.
  - Store: pc_write = 1, pc_src = 00, retire_count += 1, then -> FETCH.
- WB, one cycle:
  - reg_write = 1; mem_to_reg = 1 for load only.
  - pc_write = 1; pc_src = 01 for JAL, 10 for JALR, otherwise 00.
  - retire_count += 1; -> FETCH.
- Timeout:
  - Counter increments each cycle in FETCH/MEM while mem_ready = 0; clears on every state change.
  - Count reaching TIMEOUT_CYCLES with mem_ready still 0 -> TRAP, bus_err = 1.
  - mem_ready arriving in that same cycle wins: no trap.
- TRAP: all strobes 0; remain until reset. illegal and bus_err are never both set.
- mem_req, mem_we and mem_addr_sel stay stable until the mem_ready cycle; they never drop early.
- Latency per class, in cycles:
  - Branch: 3 + fetch wait.
  - ALU/LUI/AUIPC/JAL/JALR: 4 + fetch wait.
  - Store: 4 + waits.
  - Load: 5 + waits.

Decomposition:
- Package mc_pkg holds:
  - state enum;
  - opcode localparams;
  - alu_op encodings;
  - pc_src encodings.
- Sub-module mc_alu_decode: combinational opcode/funct3/funct7 -> alu_op, alu_src, illegal. Instantiated once and used in DECODE and EXEC.

Test Plan:
- Reset release, memory ready immediately, instr 0x00208133 (add):
  - state sequence IDLE, FETCH, DECODE, EXEC, WB, FETCH;
  - alu_op = 0000 and reg_write = 1 in WB;
  - retire_count = 1.
- Load 0x0000A103 with mem_ready delayed 3 cycles in MEM:
  - mem_req, mem_addr_sel = 1 and mem_we = 0 held 4 cycles;
  - WB asserts mem_to_reg = 1 and reg_write = 1.
- Branch 0x00208463 with branch_taken = 1, then 0:
  - first: pc_write = 1, pc_src = 01 in EXEC, no reg_write, back to FETCH;
  - second: pc_src = 00.
- Instr 0x0000007F:
  - TRAP entered after DECODE, illegal = 1;
  - strobes stay 0 for 20 cycles;
  - rst pulse clears to IDLE.
- FETCH with mem_ready held 0:
  - bus_err = 1 and TRAP after TIMEOUT_CYCLES = 16 cycles;
  - repeat with mem_ready arriving in cycle 16: no trap.
- rst asserted mid-MEM of a store:
  - mem_req and mem_we drop immediately; retire_count = 0;
  - FETCH on the first clock after release.
